// File: rtl/spi_regfile_rw_if.sv
// SPI mode-0 pin bundle shared by the register-file peripheral and its controller.
interface spi_regfile_rw_if;
  logic sclk;
  logic ncs;
  logic copi;
  logic cipo;
  logic cipo_oe;

  modport master (output sclk, output ncs, output copi, input cipo, input cipo_oe);
  modport slave  (input sclk, input ncs, input copi, output cipo, output cipo_oe);
endinterface

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 peripheral exposing NUM_REGS x DATA_W readable/writable config registers,
// with per-register write strobes and a saturating rejected-frame counter.
module spi_regfile_rw #(
  parameter int NUM_REGS    = 8,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_regfile_rw_if.slave            spi,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic [ERR_W-1:0]           err_count
);

  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA_1ST  = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(ADDR_W + DATA_W);
  localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_LEN);
  localparam logic [ADDR_W:0]  NUM_REGS_L    = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_DONE} state_t;

  state_t                      state_r, state_s;
  logic [SYNC_STAGES-1:0]      sclk_sync_r, ncs_sync_r, copi_sync_r;
  logic                        sclk_prev_r, ncs_prev_r;
  logic                        sclk_q_s, ncs_q_s, copi_q_s;
  logic                        sclk_rise_s, sclk_fall_s, ncs_fall_s, ncs_rise_s;
  logic [CNT_W-1:0]            bit_cnt_r;
  logic                        rw_r, overrun_r, commit_r;
  logic [ADDR_W-1:0]           addr_r, addr_next_s;
  logic [DATA_W-1:0]           data_r, tx_r, rd_data_s;
  logic                        cipo_r, cipo_oe_r;
  logic [NUM_REGS*DATA_W-1:0]  reg_r;
  logic [NUM_REGS-1:0]         wr_strobe_r;
  logic [ERR_W-1:0]            err_r;
  logic                        frame_ok_s, write_ok_s, read_ok_s;

  assign sclk_q_s    = sclk_sync_r[SYNC_STAGES-1];
  assign ncs_q_s     = ncs_sync_r[SYNC_STAGES-1];
  assign copi_q_s    = copi_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_q_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_q_s & sclk_prev_r;
  assign ncs_fall_s  = ~ncs_q_s & ncs_prev_r;
  assign ncs_rise_s  = ncs_q_s & ~ncs_prev_r;
  assign addr_next_s = {addr_r[ADDR_W-2:0], copi_q_s};

  assign frame_ok_s = (bit_cnt_r == CNT_FULL) & ~overrun_r;
  assign write_ok_s = rw_r & frame_ok_s & ({1'b0, addr_r} < NUM_REGS_L);
  assign read_ok_s  = ~rw_r & frame_ok_s;

  assign spi.cipo    = cipo_r;
  assign spi.cipo_oe = cipo_oe_r;
  assign reg_out     = reg_r;
  assign wr_strobe   = wr_strobe_r;
  assign err_count   = err_r;

  // Synchronise the async SPI pins and keep one previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_r <= '0;
      ncs_sync_r  <= '1;
      copi_sync_r <= '0;
      sclk_prev_r <= 1'b0;
      ncs_prev_r  <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.sclk};
      ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], spi.ncs};
      copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], spi.copi};
      sclk_prev_r <= sclk_q_s;
      ncs_prev_r  <= ncs_q_s;
    end
  end

  // Read mux; addresses with no register fall through to zero.
  always_comb begin
    rd_data_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s = rd_data_s | (reg_r[i*DATA_W +: DATA_W] & {DATA_W{addr_next_s == ADDR_W'(i)}});
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame next-state: chip-select edges win over sclk activity.
  always_comb begin
    state_s = state_r;
    if (ncs_fall_s) begin
      state_s = ST_CMD;
    end else if (ncs_rise_s) begin
      state_s = ST_IDLE;
    end else if (sclk_rise_s && !ncs_q_s) begin
      case (state_r)
        ST_CMD:  state_s = ST_ADDR;
        ST_ADDR: state_s = (bit_cnt_r == CNT_ADDR_LAST) ? ST_DATA : ST_ADDR;
        ST_DATA: state_s = (bit_cnt_r == CNT_DATA_LAST) ? ST_DONE : ST_DATA;
        default: state_s = state_r;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Shift datapath, readback driver, commit/reject and register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r   <= '0;
      rw_r        <= 1'b0;
      overrun_r   <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      tx_r        <= '0;
      cipo_r      <= 1'b0;
      cipo_oe_r   <= 1'b0;
      commit_r    <= 1'b0;
      reg_r       <= '0;
      wr_strobe_r <= '0;
      err_r       <= '0;
    end else begin
      commit_r    <= 1'b0;
      wr_strobe_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit_r && addr_r == ADDR_W'(i)) begin
          reg_r[i*DATA_W +: DATA_W] <= data_r;
          wr_strobe_r[i]            <= 1'b1;
        end
      end

      if (ncs_fall_s) begin
        bit_cnt_r <= '0;
        rw_r      <= 1'b0;
        overrun_r <= 1'b0;
        addr_r    <= '0;
        data_r    <= '0;
        tx_r      <= '0;
        cipo_r    <= 1'b0;
        cipo_oe_r <= 1'b0;
      end else if (ncs_rise_s) begin
        cipo_r    <= 1'b0;
        cipo_oe_r <= 1'b0;
        if (bit_cnt_r != '0) begin
          if (write_ok_s) begin
            commit_r <= 1'b1;
          end else if (!read_ok_s && err_r != '1) begin
            err_r <= err_r + ERR_W'(1);
          end
        end
      end else if (!ncs_q_s && state_r != ST_IDLE) begin
        if (sclk_rise_s) begin
          if (bit_cnt_r == CNT_FULL) begin
            overrun_r <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          end
          case (state_r)
            ST_CMD:  rw_r <= copi_q_s;
            ST_ADDR: begin
              addr_r <= addr_next_s;
              if (bit_cnt_r == CNT_ADDR_LAST && !rw_r) begin
                tx_r      <= rd_data_s << 1;
                cipo_r    <= rd_data_s[DATA_W-1];
                cipo_oe_r <= 1'b1;
              end
            end
            ST_DATA: data_r <= {data_r[DATA_W-2:0], copi_q_s};
            default: ;
          endcase
        end else if (sclk_fall_s && cipo_oe_r && bit_cnt_r > CNT_DATA_1ST) begin
          // The fall right after the address phase must not shift: the MSB is still being sampled.
          cipo_r <= tx_r[DATA_W-1];
          tx_r   <= tx_r << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Scoreboard bench for spi_regfile_rw: writes/reads/bad frames against a small register model.
module tb_spi_regfile_rw;
  localparam int NR = 8;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int SS = 2;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_regfile_rw_if spi();
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    wr_strobe;
  logic [EW-1:0]    err_count;

  spi_regfile_rw #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .spi(spi.slave),
    .reg_out(reg_out), .wr_strobe(wr_strobe), .err_count(err_count)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] mdl_regs [NR];
  int            mdl_err;
  wr_exp_t       wr_q[$];
  logic [DW-1:0] rd_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl_regs[i];
    return f;
  endfunction

  task automatic check_state(input string tag);
    check_val({tag, "_regs"}, reg_out, mdl_flat());
    check_val({tag, "_err"}, err_count, mdl_err);
  endtask

  // Every write strobe is a DUT output event; pop the expected write and compare.
  always @(negedge clk) begin
    if (!rst && wr_strobe != '0) begin
      if (wr_q.size() == 0) begin
        check_val("wr_unexpected", wr_strobe, 0);
      end else begin
        wr_exp_t e;
        int      idx;
        e   = wr_q.pop_front();
        idx = int'(e.addr);
        check_val("wr_strobe", wr_strobe, 64'(1) << idx);
        check_val("wr_data", reg_out[idx*DW +: DW], e.data);
      end
    end
  end

  task automatic spi_xfer(input int nbits, input logic [31:0] word, input bit is_read,
                          input bit exp_commit, input int abort_at);
    logic [DW-1:0] rd;
    bit            oe_addr, oe_data;
    int            lat;
    rd = '0; oe_addr = 1'b0; oe_data = 1'b1;
    @(negedge clk) spi.ncs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_regs", reg_out, 0);
        check_val("rst_strobe", wr_strobe, 0);
        check_val("rst_err", err_count, 0);
        check_val("rst_cipo", {spi.cipo_oe, spi.cipo}, 0);
        rst = 1'b0;
        spi.ncs = 1'b1;
        repeat (12) @(negedge clk);
        return;
      end
      spi.copi = word[nbits-1-i];
      repeat (8) @(negedge clk);
      if (i >= 1 + AW && i < 1 + AW + DW) begin
        rd = {rd[DW-2:0], spi.cipo};
        oe_data &= spi.cipo_oe;
      end else if (i < 1 + AW) begin
        oe_addr |= spi.cipo_oe;
      end
      spi.sclk = 1'b1;
      repeat (8) @(negedge clk);
      spi.sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    spi.ncs = 1'b1;
    if (exp_commit) begin
      lat = 0;
      while (wr_strobe == '0 && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check_val("wr_latency", lat, SS + 2);
    end
    repeat (12) @(negedge clk);
    if (is_read) begin
      check_val("rd_oe_addr_phase", oe_addr, 0);
      check_val("rd_oe_data_phase", oe_data, 1);
      check_val("rd_oe_after", {spi.cipo_oe, spi.cipo}, 0);
      check_val("rd_queue", rd_q.size(), 1);
      if (rd_q.size() != 0) check_val("rd_data", rd, rd_q.pop_front());
    end
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_q.push_back({AW'(a), d});
    mdl_regs[a] = d;
    spi_xfer(16, 32'({1'b1, AW'(a), d}), 1'b0, 1'b1, -1);
  endtask

  task automatic do_read(input int a);
    rd_q.push_back((a < NR) ? mdl_regs[a] : '0);
    spi_xfer(16, 32'({1'b0, AW'(a), 8'h00}), 1'b1, 1'b0, -1);
  endtask

  task automatic bad_frame(input int nbits, input logic [31:0] word);
    mdl_err = (mdl_err == (1 << EW) - 1) ? mdl_err : mdl_err + 1;
    spi_xfer(nbits, word, 1'b0, 1'b0, -1);
  endtask

  initial begin
    rst = 1'b1;
    spi.sclk = 1'b0; spi.ncs = 1'b1; spi.copi = 1'b0;
    for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
    mdl_err = 0;
    repeat (4) @(negedge clk);
    check_val("reset_regs", reg_out, 0);
    check_val("reset_strobe", wr_strobe, 0);
    check_val("reset_err", err_count, 0);
    check_val("reset_cipo", {spi.cipo_oe, spi.cipo}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    do_write(3, 8'hA5);
    check_state("write_reg3");

    do_write(5, 8'h3C);
    do_read(5);
    check_state("read_reg5");

    bad_frame(16, 32'({1'b1, 7'd9, 8'hFF}));
    check_state("write_oob");
    do_read(9);
    check_state("read_oob");

    bad_frame(12, 32'({1'b1, 7'd0, 8'h77}) >> 4);
    bad_frame(17, 32'({1'b1, 7'd0, 8'h77, 1'b0}));
    check_state("short_long");

    spi_xfer(0, 32'h0, 1'b0, 1'b0, -1);
    check_state("empty_frame");
    spi.copi = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat (4) @(negedge clk) spi.sclk = ~spi.sclk;
    end
    repeat (12) @(negedge clk);
    check_state("sclk_ncs_high");

    do_write(1, 8'h12);
    spi_xfer(16, 32'({1'b1, 7'd1, 8'h55}), 1'b0, 1'b0, 10);
    for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
    mdl_err = 0;
    check_state("after_rst");
    do_write(1, 8'h55);
    check_state("write_after_rst");

    for (int a = 0; a < NR; a++) do_write(a, DW'($urandom_range(0, 255)));
    for (int a = 0; a < NR; a++) do_read(a);
    check_state("all_regs");

    while (mdl_err < (1 << EW) - 1) bad_frame(1, 32'h1);
    check_state("err_full");
    bad_frame(1, 32'h1);
    check_state("err_saturate");

    check_val("wr_q_left", wr_q.size(), 0);
    check_val("rd_q_left", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_regfile_rw.md
Name: spi_regfile_rw

Overview:
Parametrised SPI mode-0 peripheral exposing a bank of NUM_REGS configuration registers, each DATA_W bits wide, to the chip-level logic (output enables, PWM enables, duty cycle, and later additions).
- Successor to the current write-only configuration peripheral.
- Adds readback over CIPO, a parametrised register count and width, per-register write strobes, and a saturating frame-error counter.
- All SPI inputs are asynchronous; the block samples them in the clk domain.

Parameters:
NUM_REGS, 8, number of implemented registers (addresses 0..NUM_REGS-1)
DATA_W, 8, register and data-field width in bits
ADDR_W, 7, address-field width in bits; NUM_REGS <= 2^ADDR_W
SYNC_STAGES, 2, synchroniser flops on sclk/ncs/copi (>=2)
ERR_W, 8, width of the frame-error counter

Ports:
clk  in  1  system clock; must be at least 8x sclk
rst  in  1  synchronous, active-high reset
sclk  in  1  SPI clock, async, idle low
ncs  in  1  SPI chip select, async, active low
copi  in  1  controller-out data, async
cipo  out  1  peripheral-out data (registered)
cipo_oe  out  1  high while a read frame is in its data phase
reg_out  out  NUM_REGS*DATA_W  flat register bank; reg N at [N*DATA_W +: DATA_W]
wr_strobe  out  NUM_REGS  one-clk pulse on the cycle register N is updated
err_count  out  ERR_W  saturating count of rejected frames

Behaviour:
- Reset (rst high at posedge clk) clears the following, whatever else is happening:
  - all reg_out bits, wr_strobe, err_count, cipo, cipo_oe: 0
  - synchronisers: sclk=0, ncs=1, copi=0
  - frame state: IDLE
- Edge detection uses the last two synchronised samples. sclk rise/fall and ncs fall/rise are each one-clk events.
- Frame format, MSB first: 1 rw bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits. FRAME_LEN = 1+ADDR_W+DATA_W.
- State machine: IDLE -> CMD -> ADDR -> DATA -> DONE.
  - ncs fall: any -> CMD; clears bit counter, address and data shift registers.
  - CMD: sclk rise samples rw -> ADDR.
  - ADDR: ADDR_W sclk rises shift the address -> DATA.
  - DATA: DATA_W rises shift data -> DONE.
  - DONE: further sclk rises set an overrun flag; the counter saturates at FRAME_LEN.
  - ncs rise: any -> IDLE, with commit/reject decided as below.
- Write commit on ncs rise happens only if rw=1, bit count == FRAME_LEN, no overrun, and address < NUM_REGS.
  - Register update and a single wr_strobe bit assert on the clk after the ncs-rise event.
- Read frames: on the sclk rise capturing the last address bit, load the tx shift register in the same clk.
  - Source is the addressed register, or all zeros if address >= NUM_REGS.
  - cipo is driven with the MSB and cipo_oe asserts.
  - Each subsequent sclk fall shifts the next bit onto cipo.
  - cipo_oe and cipo drop to 0 on ncs rise or on entering IDLE.
  - Reads never modify registers and never strobe.
- Rejected frame: err_count increments by 1 on ncs rise, saturating at all-ones. Causes are:
  - wrong bit count (short, or overrun) for either rw
  - write with address >= NUM_REGS
- An ncs rise with zero bits clocked is ignored; no error is counted.
- A new ncs fall before a pending commit completes is impossible at the required clk/sclk ratio; the commit always completes first.
- Reset mid-frame discards the frame; no commit, no error increment.
- sclk edges while ncs is high are ignored.
- Latency: write data is visible on reg_out SYNC_STAGES+2 clk after the physical ncs rise.

Test Plan:
- Write 1_0000011_10100101 (ADDR_W=7, DATA_W=8) -> reg 3 = 0xA5, wr_strobe = 0x08 for exactly 1 clk, other regs unchanged, err_count = 0.
- Preload reg 5 = 0x3C, then read 0_0000101_xxxxxxxx -> cipo bits 0,0,1,1,1,1,0,0 sampled on the 8 data sclk rises; cipo_oe high only in the data phase; reg 5 still 0x3C.
- Write to address 0x09 (>= NUM_REGS) with 0xFF -> no reg change, no strobe, err_count = 1; read of 0x09 returns 0x00, and err_count stays 1 because the read is well-formed.
- Truncated 12-bit write, then 17-bit write to reg 0 -> both rejected, reg 0 unchanged, err_count += 2.
- Assert rst after 10 bits of a write to reg 1 -> all outputs 0; the following complete write to reg 1 with 0x55 succeeds.
- Force err_count to 2^ERR_W-1 with bad frames, send one more bad frame -> err_count stays at all-ones.
